tile_map_writer: RTL and testbench
==================================

TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 The block SHALL have parameter MAP_W, default 20, giving map width in tiles.
REQ-002 The block SHALL have parameter MAP_H, default 15, giving map height in tiles.
REQ-003 The block SHALL have parameter TILE_BITS, default 4, giving tile ID width.
REQ-004 The block SHALL have port clk, input, 1 bit: 25 MHz pixel clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port vblank, input, 1 bit: high during vertical blanking (v_cnt >= 480).
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: command accepted when both cmd_valid and cmd_ready are high.
REQ-009 The block SHALL have port cmd_op, input, 2 bits: 0=WRITE, 1=FILL, 2=CLEAR, 3=reserved.
REQ-010 The block SHALL have ports cmd_gx (input, 5 bits), cmd_gy (input, 4 bits), cmd_len (input, 5 bits) and cmd_tile (input, TILE_BITS bits), giving command operands.
REQ-011 The block SHALL have ports map_we (output, 1 bit), map_waddr (output, 9 bits) and map_wdata (output, TILE_BITS bits), forming the tile-RAM write port.
REQ-012 The block SHALL have ports busy, done and err, each an output of 1 bit: status.

Function
REQ-013 The map address SHALL be computed as gy*MAP_W+gx, 9-bit unsigned, row-major, range 0..299.
REQ-014 cmd_ready SHALL be high exactly when the FSM is in IDLE.
REQ-015 Accepted operands SHALL be latched on the accept cycle, and later changes on the cmd_* inputs SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, CHECK, WAIT_VB, WRITE and FINISH.
REQ-017 On accept, the FSM SHALL go IDLE->CHECK.
REQ-018 CHECK SHALL reject the command if any of these hold: cmd_op==3; gx>=MAP_W; gy>=MAP_H; FILL with len==0; FILL with gx+len>MAP_W.
REQ-019 On rejection, the FSM SHALL go to FINISH with err=1 and perform no writes.
REQ-020 CHECK SHALL otherwise go to WAIT_VB.
REQ-021 WAIT_VB SHALL go to WRITE when the write gate (REQ-035/036) is open, and SHALL otherwise hold.
REQ-022 WRITE SHALL perform one write per cycle with map_we=1.
REQ-023 A WRITE command SHALL perform 1 write at addr(gx,gy) with data cmd_tile.
REQ-024 A FILL command SHALL perform len writes at addr(gx,gy)..addr(gx,gy)+len-1 with data cmd_tile.
REQ-025 A CLEAR command SHALL perform 300 writes at addresses 0..MAP_W*MAP_H-1 with data 0 (T_EMPTY), ignoring gx, gy, len and tile.
REQ-026 If the write gate closes during WRITE, the FSM SHALL return to WAIT_VB with map_we=0 and the current address and remaining count preserved, and SHALL resume without skipping or repeating any address.
REQ-027 After the last write, the FSM SHALL go to FINISH.
REQ-028 FINISH SHALL last one cycle, pulse done=1 (and err=1 for rejected commands), then return to IDLE.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 With the gate open, latency SHALL be: accept at cycle N, CHECK at N+1, WAIT_VB at N+2, first write at N+3, and done one cycle after the last write.
REQ-031 The block SHALL never assert map_we with map_waddr >= MAP_W*MAP_H.
REQ-032 cmd_valid asserted while busy SHALL be ignored and the command SHALL stay pending, since ready is low.

Reset
REQ-033 Asserting rst at any time SHALL immediately force state=IDLE and map_we=0, map_waddr=0, map_wdata=0, busy=0, done=0, err=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no done pulse, and SHALL leave already-written RAM entries unchanged.

Configuration
REQ-035 With macro TILE_MAP_VBLANK_SYNC_EN defined, the write gate SHALL equal vblank, so RAM changes occur only during blanking and no tile changes mid-frame.
REQ-036 With TILE_MAP_VBLANK_SYNC_EN undefined, the write gate SHALL be constant 1, the vblank input SHALL be unused, and WAIT_VB SHALL pass through in one cycle.

Structure
REQ-037 Package tile_map_pkg SHALL hold the tile ID constants (T_EMPTY=0, T_SPIKE=1, T_GATE_1..3=2..4, T_PLATE_1..3=5..7, T_EXIT=8, T_WALL=9), MAP_W, MAP_H and the cmd_op encodings; mem_addr_gen's decoder SHALL share these constants.
REQ-038 One sub-module, tile_addr_calc, SHALL provide the combinational gx,gy->address conversion as (gy<<4)+(gy<<2)+gx with no multiplier.

Verification
REQ-039 The bench SHALL cover: macro off, WRITE gx=7, gy=9, tile=2 -> single map_we at addr 187 with data 2 at N+3, and done at N+4.
REQ-040 The bench SHALL cover: macro off, FILL gx=2, gy=11, len=3, tile=5 -> writes at addrs 222, 223, 224 on consecutive cycles, then done.
REQ-041 The bench SHALL cover: macro on, CLEAR with vblank toggling every 50 cycles -> exactly 300 writes, addrs 0..299 each exactly once, all with data 0, and map_we=0 whenever vblank=0.
REQ-042 The bench SHALL cover: FILL gx=18, len=3 and WRITE gy=15 -> no map_we, and done=1 with err=1 one cycle after CHECK.
REQ-043 The bench SHALL cover: rst pulsed at the 100th write of a CLEAR -> outputs zero immediately, no done, cmd_ready=1 after release, and a following WRITE completes normally.

Source files
------------

// File: rtl/tile_map_pkg.sv
// rtl/tile_map_pkg.sv - shared tile IDs, map geometry, command and FSM encodings
//
// Shared by tile_map_writer, tile_addr_calc and the tile-RAM address
// decoder so every block agrees on tile IDs and map geometry.
package tile_map_pkg;

    localparam int MAP_W = 20;
    localparam int MAP_H = 15;

    localparam logic [3:0] T_EMPTY   = 4'd0;
    localparam logic [3:0] T_SPIKE   = 4'd1;
    localparam logic [3:0] T_GATE_1  = 4'd2;
    localparam logic [3:0] T_GATE_2  = 4'd3;
    localparam logic [3:0] T_GATE_3  = 4'd4;
    localparam logic [3:0] T_PLATE_1 = 4'd5;
    localparam logic [3:0] T_PLATE_2 = 4'd6;
    localparam logic [3:0] T_PLATE_3 = 4'd7;
    localparam logic [3:0] T_EXIT    = 4'd8;
    localparam logic [3:0] T_WALL    = 4'd9;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_WAIT_VB = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } wr_state_t;

endpackage

// File: rtl/tile_addr_calc.sv
// rtl/tile_addr_calc.sv - grid coordinate to row-major tile-RAM address
//
// Purpose: addr = gy*20 + gx, built from shifts and adds (gy*16 + gy*4 + gx)
//          so no multiplier is inferred.
// Ports:
//   gx   - column, 5 bits
//   gy   - row, 4 bits
//   addr - 9-bit row-major address (max 15*20+31 = 331, fits in 9 bits)
module tile_addr_calc (
    input  logic [4:0] gx,
    input  logic [3:0] gy,
    output logic [8:0] addr
);

    logic [8:0] gy_w;
    logic [8:0] gx_w;

    assign gy_w = {5'b0, gy};
    assign gx_w = {4'b0, gx};
    assign addr = (gy_w << 4) + (gy_w << 2) + gx_w;

endmodule

// File: rtl/tile_map_writer.sv
// rtl/tile_map_writer.sv - command-driven writer for the tile-map RAM
//
// Purpose: accepts WRITE / FILL / CLEAR commands, range-checks them, then
//          streams one tile-RAM write per cycle while the write gate is open.
// Optional feature: define TILE_MAP_VBLANK_SYNC_EN to gate writes with vblank
//          so the map never changes mid-frame; otherwise the gate is always
//          open and vblank is ignored.
// Ports:
//   clk, rst                - pixel clock, asynchronous active-high reset
//   vblank                  - vertical blanking (used only with the macro)
//   cmd_valid / cmd_ready   - command handshake (ready only in IDLE)
//   cmd_op, cmd_gx, cmd_gy,
//   cmd_len, cmd_tile       - command operands, latched on accept
//   map_we/waddr/wdata      - tile-RAM write port
//   busy, done, err         - status; done/err pulse for one cycle in FINISH
module tile_map_writer #(
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int TILE_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vblank,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [4:0]           cmd_gx,
    input  logic [3:0]           cmd_gy,
    input  logic [4:0]           cmd_len,
    input  logic [TILE_BITS-1:0] cmd_tile,
    output logic                 map_we,
    output logic [8:0]           map_waddr,
    output logic [TILE_BITS-1:0] map_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    import tile_map_pkg::*;

    localparam logic [5:0] MAP_W6 = 6'(MAP_W);
    localparam logic [4:0] MAP_H5 = 5'(MAP_H);
    localparam logic [8:0] CELLS  = 9'(MAP_W * MAP_H);

    wr_state_t state;
    wr_state_t state_nxt;

    cmd_op_t              op_r;
    logic [4:0]           gx_r;
    logic [3:0]           gy_r;
    logic [4:0]           len_r;
    logic [TILE_BITS-1:0] tile_r;

    logic [8:0]           addr_r;
    logic [8:0]           remain_r;
    logic [TILE_BITS-1:0] wdata_r;
    logic                 rej_r;

    logic [8:0]           start_addr;
    logic                 cmd_bad;
    logic                 gate;

    tile_addr_calc u_addr_calc (
        .gx   (gx_r),
        .gy   (gy_r),
        .addr (start_addr)
    );

`ifdef TILE_MAP_VBLANK_SYNC_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    // CLEAR covers the whole map regardless of operands, so only WRITE and
    // FILL are range-checked; the reserved opcode is always refused.
    always_comb begin
        cmd_bad = 1'b0;
        case (op_r)
            OP_WRITE: cmd_bad = ({1'b0, gx_r} >= MAP_W6) || ({1'b0, gy_r} >= MAP_H5);
            OP_FILL:  cmd_bad = ({1'b0, gx_r} >= MAP_W6) || ({1'b0, gy_r} >= MAP_H5)
                                || (len_r == 5'd0)
                                || (({1'b0, gx_r} + {1'b0, len_r}) > MAP_W6);
            OP_CLEAR: cmd_bad = 1'b0;
            default:  cmd_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        map_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = cmd_bad ? ST_FINISH : ST_WAIT_VB;
            end
            ST_WAIT_VB: begin
                if (gate) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A closing gate suppresses this cycle's write; address and
                // count are frozen so the burst resumes exactly where it paused.
                if (!gate) begin
                    state_nxt = ST_WAIT_VB;
                end else begin
                    map_we = 1'b1;
                    if (remain_r == 9'd1) begin
                        state_nxt = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                err       = rej_r;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_WRITE;
            gx_r     <= 5'd0;
            gy_r     <= 4'd0;
            len_r    <= 5'd0;
            tile_r   <= '0;
            addr_r   <= 9'd0;
            remain_r <= 9'd0;
            wdata_r  <= '0;
            rej_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op_t'(cmd_op);
                        gx_r   <= cmd_gx;
                        gy_r   <= cmd_gy;
                        len_r  <= cmd_len;
                        tile_r <= cmd_tile;
                    end
                end
                ST_CHECK: begin
                    rej_r <= cmd_bad;
                    if (op_r == OP_CLEAR) begin
                        addr_r   <= 9'd0;
                        remain_r <= CELLS;
                        wdata_r  <= TILE_BITS'(T_EMPTY);
                    end else begin
                        addr_r   <= start_addr;
                        remain_r <= (op_r == OP_FILL) ? {4'b0, len_r} : 9'd1;
                        wdata_r  <= tile_r;
                    end
                end
                ST_WRITE: begin
                    if (gate) begin
                        addr_r   <= addr_r + 9'd1;
                        remain_r <= remain_r - 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign map_waddr = addr_r;
    assign map_wdata = wdata_r;

endmodule

// File: tb/tb_tile_map_writer.sv
// tb/tb_tile_map_writer.sv - self-checking bench for tile_map_writer
module tb_tile_map_writer;

    localparam int MAP_W = 20;
    localparam int MAP_H = 15;
    localparam int CELLS = MAP_W * MAP_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblank = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_gx = 5'd0;
    logic [3:0] cmd_gy = 4'd0;
    logic [4:0] cmd_len = 5'd0;
    logic [3:0] cmd_tile = 4'd0;
    logic       map_we;
    logic [8:0] map_waddr;
    logic [3:0] map_wdata;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int done_cyc[$];
    int done_err[$];
    int gate_viol;

    int exp_addr[$];
    int exp_data;
    bit exp_rej;

    tile_map_writer #(.MAP_W(20), .MAP_H(15), .TILE_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .vblank    (vblank),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_gx    (cmd_gx),
        .cmd_gy    (cmd_gy),
        .cmd_len   (cmd_len),
        .cmd_tile  (cmd_tile),
        .map_we    (map_we),
        .map_waddr (map_waddr),
        .map_wdata (map_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #20 clk = ~clk;

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: which addresses a command must touch, with what data.
    task automatic model(input int op, input int gx, input int gy, input int len, input int tile);
        exp_addr.delete();
        exp_rej  = 1'b0;
        exp_data = tile;
        if (op == 3) begin
            exp_rej = 1'b1;
        end else if (op == 2) begin
            exp_data = 0;
            for (int a = 0; a < CELLS; a++) exp_addr.push_back(a);
        end else if (gx >= MAP_W || gy >= MAP_H) begin
            exp_rej = 1'b1;
        end else if (op == 1 && (len == 0 || gx + len > MAP_W)) begin
            exp_rej = 1'b1;
        end else if (op == 1) begin
            for (int i = 0; i < len; i++) exp_addr.push_back(gy * MAP_W + gx + i);
        end else begin
            exp_addr.push_back(gy * MAP_W + gx);
        end
    endtask

    task automatic send(input int op, input int gx, input int gy, input int len, input int tile);
        int w;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL send_ready: cmd_ready=%0b required=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_gx    = 5'(gx);
        cmd_gy    = 4'(gy);
        cmd_len   = 5'(len);
        cmd_tile  = 4'(tile);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_gx    = 5'($urandom);
        cmd_gy    = 4'($urandom);
        cmd_len   = 5'($urandom);
        cmd_tile  = 4'($urandom);
    endtask

    // Cycle k=1 is the cycle right after the accept edge.
    task automatic collect(input int n_done, input int budget, input bit toggle_vb);
        int vb_cnt;
        vb_cnt = 0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc.delete();
        done_err.delete();
        gate_viol = 0;
        for (int k = 1; k <= budget && done_cyc.size() < n_done; k++) begin
            @(negedge clk);
            if (map_we) begin
                obs_addr.push_back(int'(map_waddr));
                obs_data.push_back(int'(map_wdata));
                obs_cyc.push_back(k);
                if (!vblank) gate_viol++;
            end
            if (done) begin
                done_cyc.push_back(k);
                done_err.push_back(int'(err));
            end
            if (toggle_vb) begin
                vb_cnt++;
                if (vb_cnt % 50 == 0) vblank = ~vblank;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({map_we, map_waddr, map_wdata, busy, done, err} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs: we=%0b addr=%0d data=%0d busy=%0b done=%0b err=%0b required all 0",
                     map_we, map_waddr, map_wdata, busy, done, err);
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: cmd_ready=%0b required=1", cmd_ready);
        end
    endtask

    task automatic test_write_single();
        send(0, 7, 9, 0, 2);
        collect(1, 50, 1'b0);
        tests++;
        if (obs_addr.size() != 1) begin
            fails++;
            $display("FAIL write_count: writes=%0d required=1", obs_addr.size());
        end else begin
            tests++;
            if (obs_addr[0] != 187 || obs_data[0] != 2 || obs_cyc[0] != 3) begin
                fails++;
                $display("FAIL write_beat: addr=%0d data=%0d cyc=%0d required addr=187 data=2 cyc=3",
                         obs_addr[0], obs_data[0], obs_cyc[0]);
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 4 || done_err[0] != 0) begin
            fails++;
            $display("FAIL write_done: ndone=%0d cyc=%0d err=%0d required cyc=4 err=0",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, done_err.size() ? done_err[0] : -1);
        end
    endtask

    task automatic test_fill_row();
        send(1, 2, 11, 3, 5);
        collect(1, 50, 1'b0);
        tests++;
        if (obs_addr.size() != 3) begin
            fails++;
            $display("FAIL fill_count: writes=%0d required=3", obs_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (obs_addr[i] != 222 + i || obs_data[i] != 5 || obs_cyc[i] != 3 + i) begin
                    fails++;
                    $display("FAIL fill_beat%0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=5 cyc=%0d",
                             i, obs_addr[i], obs_data[i], obs_cyc[i], 222 + i, 3 + i);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 6 || done_err[0] != 0) begin
            fails++;
            $display("FAIL fill_done: ndone=%0d cyc=%0d required cyc=6 err=0",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_reject();
        int ops[4]  = '{1, 0, 3, 1};
        int gxs[4]  = '{18, 3, 0, 4};
        int gys[4]  = '{2, 15, 0, 4};
        int lens[4] = '{3, 0, 1, 0};
        for (int t = 0; t < 4; t++) begin
            send(ops[t], gxs[t], gys[t], lens[t], 9);
            collect(1, 50, 1'b0);
            tests++;
            if (obs_addr.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != 2 || done_err[0] != 1) begin
                fails++;
                $display("FAIL reject%0d: writes=%0d ndone=%0d done_cyc=%0d err=%0d required writes=0 done_cyc=2 err=1",
                         t, obs_addr.size(), done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1,
                         done_err.size() ? done_err[0] : -1);
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            int r, op, gx, gy, len, tile, exp_done, bad;
            r    = $urandom_range(0, 19);
            op   = (r < 8) ? 0 : (r < 16) ? 1 : (r < 17) ? 2 : 3;
            gx   = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
            gy   = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 14);
            if (gx < MAP_W && $urandom_range(0, 1) == 1) len = $urandom_range(1, MAP_W - gx);
            else len = $urandom_range(0, 31);
            tile = $urandom_range(0, 15);
            model(op, gx, gy, len, tile);
            send(op, gx, gy, len, tile);
            collect(1, 600, 1'b0);
            exp_done = exp_rej ? 2 : 3 + exp_addr.size();
            tests++;
            if (done_cyc.size() != 1 || done_cyc[0] != exp_done || done_err[0] != int'(exp_rej)) begin
                fails++;
                $display("FAIL rand%0d_done: op=%0d gx=%0d gy=%0d len=%0d ndone=%0d cyc=%0d err=%0d required cyc=%0d err=%0d",
                         t, op, gx, gy, len, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1,
                         done_err.size() ? done_err[0] : -1, exp_done, exp_rej);
            end
            tests++;
            if (obs_addr.size() != exp_addr.size()) begin
                fails++;
                $display("FAIL rand%0d_count: op=%0d writes=%0d required=%0d", t, op, obs_addr.size(), exp_addr.size());
            end else begin
                bad = 0;
                for (int i = 0; i < exp_addr.size(); i++)
                    if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data || obs_cyc[i] != 3 + i) bad++;
                tests++;
                if (bad != 0) begin
                    fails++;
                    $display("FAIL rand%0d_beats: op=%0d bad_beats=%0d required=0", t, op, bad);
                end
            end
        end
    endtask

    task automatic test_clear_vblank();
        int seen[CELLS];
        int bad;
        for (int a = 0; a < CELLS; a++) seen[a] = 0;
        vblank = 1'b0;
        send(2, 3, 3, 7, 11);
        collect(1, 2000, 1'b1);
        vblank = 1'b1;
        bad = 0;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (obs_addr[i] >= CELLS || obs_data[i] != 0) bad++;
            else seen[obs_addr[i]]++;
        end
        for (int a = 0; a < CELLS; a++) if (seen[a] != 1) bad++;
        tests++;
        if (obs_addr.size() != CELLS || bad != 0) begin
            fails++;
            $display("FAIL clear_cover: writes=%0d bad=%0d required writes=300 bad=0", obs_addr.size(), bad);
        end
        tests++;
        if (done_cyc.size() != 1 || done_err[0] != 0) begin
            fails++;
            $display("FAIL clear_done: ndone=%0d required=1 err=0", done_cyc.size());
        end
`ifdef TILE_MAP_VBLANK_SYNC_EN
        tests++;
        if (gate_viol != 0) begin
            fails++;
            $display("FAIL clear_gate: writes_outside_vblank=%0d required=0", gate_viol);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int nw, k, extra;
        send(2, 0, 0, 0, 0);
        nw = 0;
        k  = 0;
        while (nw < 100 && k < 1000) begin
            @(negedge clk);
            k++;
            if (map_we) nw++;
        end
        tests++;
        if (nw != 100) begin
            fails++;
            $display("FAIL rstmid_reach: writes=%0d required=100", nw);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({map_we, map_waddr, map_wdata, busy, done, err} !== 17'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: we=%0b addr=%0d data=%0d busy=%0b done=%0b err=%0b required all 0",
                     map_we, map_waddr, map_wdata, busy, done, err);
        end
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || map_we || busy || !cmd_ready) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL rstmid_quiet: active_cycles=%0d required=0", extra);
        end
        model(0, 19, 14, 0, 9);
        send(0, 19, 14, 0, 9);
        collect(1, 50, 1'b0);
        tests++;
        if (obs_addr.size() != 1 || obs_addr[0] != exp_addr[0] || obs_data[0] != 9 || obs_cyc[0] != 3
            || done_cyc.size() != 1 || done_cyc[0] != 4) begin
            fails++;
            $display("FAIL rstmid_after: writes=%0d addr=%0d required writes=1 addr=%0d done_cyc=4",
                     obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1, exp_addr[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k, a_done, b_acc, b_wr, b_done, b_addr, rdy_viol;
        bit pend;
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_gx = 5'd10; cmd_gy = 4'd0; cmd_len = 5'd4; cmd_tile = 4'd3;
        @(posedge clk);
        #1;
        // Second command held on the bus while the first is still running.
        cmd_op = 2'd0; cmd_gx = 5'd5; cmd_gy = 4'd1; cmd_len = 5'd0; cmd_tile = 4'd8;
        pend = 1'b1;
        a_done = -1; b_acc = -1; b_wr = -1; b_done = -1; b_addr = -1; rdy_viol = 0;
        k = 0;
        while (k < 60 && b_done < 0) begin
            @(negedge clk);
            k++;
            if (busy && cmd_ready) rdy_viol++;
            if (done) begin
                if (a_done < 0) a_done = k;
                else b_done = k;
            end
            if (map_we && b_acc >= 0) begin
                b_wr = k;
                b_addr = int'(map_waddr);
            end
            if (pend && cmd_ready) begin
                b_acc = k;
                pend = 1'b0;
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        tests++;
        if (a_done != 7 || b_acc != a_done + 1) begin
            fails++;
            $display("FAIL b2b_accept: a_done=%0d b_accept=%0d required a_done=7 b_accept=8", a_done, b_acc);
        end
        tests++;
        if (b_wr != b_acc + 3 || b_addr != 25 || b_done != b_acc + 4 || rdy_viol != 0) begin
            fails++;
            $display("FAIL b2b_second: wr_cyc=%0d addr=%0d done_cyc=%0d rdy_viol=%0d required wr=%0d addr=25 done=%0d viol=0",
                     b_wr, b_addr, b_done, rdy_viol, b_acc + 3, b_acc + 4);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write_single();
        test_fill_row();
        test_reject();
        test_back_to_back();
        test_random(40);
        test_clear_vblank();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
